sram_axi_arb2: RTL and testbench

//  2-master to 1-slave AXI4-Lite arbiter placed in front of the on-chip SRAM slave.

---
 rtl/sram_axi_arb2_pkg.sv | 24 ++
 rtl/sram_axi_arb2_rr_arb2.sv | 19 +
 rtl/sram_axi_arb2.sv | 178 +++++++++++++++++
 tb/tb_sram_axi_arb2.sv | 482 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sram_axi_arb2_pkg.sv
// Shared constants and helpers for the two-master SRAM AXI4-Lite arbiter.
// Optional feature macro: SRAM_ARB_FIXPRI_EN (fixed priority, m0 always wins).
package sram_axi_arb2_pkg;

  // Bus widths of the memory subsystem (address bus and data bus).
  localparam int unsigned MEM_ADDR_W = 32;
  localparam int unsigned MEM_DATA_W = 32;

  // FSM encodings.
  localparam logic ST_IDLE    = 1'b0;
  localparam logic ST_RD_WAIT = 1'b1;

  // Round-robin pick between two requesters; ptr names the favoured one.
  function automatic logic [1:0] pick_rr(input logic [1:0] req, input logic ptr);
    logic [1:0] gnt;
    if (ptr) begin
      gnt = {req[1], req[0] & ~req[1]};
    end else begin
      gnt = {req[1] & ~req[0], req[0]};
    end
    return gnt;
  endfunction

endpackage

// File: rtl/sram_axi_arb2_rr_arb2.sv
// Two-way one-hot grant picker used by the SRAM arbiter.
// Optional feature macro: SRAM_ARB_FIXPRI_EN (ptr ignored, req[0] always wins).
module rr_arb2
  import sram_axi_arb2_pkg::*;
(
  input  logic [1:0] req,
  input  logic       ptr,
  output logic [1:0] gnt
);

`ifdef SRAM_ARB_FIXPRI_EN
  logic unused_ptr;
  assign unused_ptr = ptr;
  assign gnt = {req[1] & ~req[0], req[0]};
`else
  assign gnt = pick_rr(req, ptr);
`endif

endmodule

// File: rtl/sram_axi_arb2.sv
// Two-master to one-slave AXI4-Lite arbiter in front of the single-port SRAM slave.
// AW+W travel together, there is no B channel, and only one read is outstanding.
// Optional feature macro: SRAM_ARB_FIXPRI_EN (fixed priority instead of round-robin).
module sram_axi_arb2
  import sram_axi_arb2_pkg::*;
#(
  parameter int unsigned ADDR_W = MEM_ADDR_W,
  parameter int unsigned DATA_W = MEM_DATA_W
) (
  input  logic                clk,
  input  logic                rst,
  // master 0 (instruction fetch)
  input  logic [ADDR_W-1:0]   m0_axi_awaddr,
  input  logic                m0_axi_awvalid,
  output logic                m0_axi_awready,
  input  logic [DATA_W-1:0]   m0_axi_wdata,
  input  logic [DATA_W/8-1:0] m0_axi_wstrb,
  input  logic                m0_axi_wvalid,
  output logic                m0_axi_wready,
  input  logic [ADDR_W-1:0]   m0_axi_araddr,
  input  logic                m0_axi_arvalid,
  output logic                m0_axi_arready,
  output logic [DATA_W-1:0]   m0_axi_rdata,
  output logic                m0_axi_rvalid,
  input  logic                m0_axi_rready,
  // master 1 (data / debug)
  input  logic [ADDR_W-1:0]   m1_axi_awaddr,
  input  logic                m1_axi_awvalid,
  output logic                m1_axi_awready,
  input  logic [DATA_W-1:0]   m1_axi_wdata,
  input  logic [DATA_W/8-1:0] m1_axi_wstrb,
  input  logic                m1_axi_wvalid,
  output logic                m1_axi_wready,
  input  logic [ADDR_W-1:0]   m1_axi_araddr,
  input  logic                m1_axi_arvalid,
  output logic                m1_axi_arready,
  output logic [DATA_W-1:0]   m1_axi_rdata,
  output logic                m1_axi_rvalid,
  input  logic                m1_axi_rready,
  // slave (SRAM)
  output logic [ADDR_W-1:0]   s_axi_awaddr,
  output logic                s_axi_awvalid,
  input  logic                s_axi_awready,
  output logic [DATA_W-1:0]   s_axi_wdata,
  output logic [DATA_W/8-1:0] s_axi_wstrb,
  output logic                s_axi_wvalid,
  input  logic                s_axi_wready,
  output logic [ADDR_W-1:0]   s_axi_araddr,
  output logic                s_axi_arvalid,
  input  logic                s_axi_arready,
  input  logic [DATA_W-1:0]   s_axi_rdata,
  input  logic                s_axi_rvalid,
  output logic                s_axi_rready
);

  logic       state_q, state_d;
  logic       owner_q, owner_d;
  logic       rr_ptr;
  logic       wr0, wr1, req0, req1;
  logic [1:0] gnt;
  logic       g_idx, g_wr;
  logic       wr_fire, rd_fire;
  logic       rready_sel;

  // A lone awvalid or wvalid is not a request; AW and W must arrive together.
  assign wr0  = m0_axi_awvalid & m0_axi_wvalid;
  assign wr1  = m1_axi_awvalid & m1_axi_wvalid;
  assign req0 = wr0 | m0_axi_arvalid;
  assign req1 = wr1 | m1_axi_arvalid;

  rr_arb2 u_rr_arb2 (
    .req (({req1, req0})),
    .ptr (rr_ptr),
    .gnt (gnt)
  );

  assign g_idx = gnt[1];
  // Write wins over read within the granted master, matching the slave.
  assign g_wr  = g_idx ? wr1 : wr0;

  // rdata is broadcast; each master qualifies it with its own rvalid.
  assign m0_axi_rdata = rst ? '0 : s_axi_rdata;
  assign m1_axi_rdata = rst ? '0 : s_axi_rdata;

  // Route the granted master to the slave and decode handshakes and next state.
  always_comb begin
    state_d        = state_q;
    owner_d        = owner_q;
    wr_fire        = 1'b0;
    rd_fire        = 1'b0;
    rready_sel     = 1'b0;
    s_axi_awaddr   = '0;
    s_axi_awvalid  = 1'b0;
    s_axi_wdata    = '0;
    s_axi_wstrb    = '0;
    s_axi_wvalid   = 1'b0;
    s_axi_araddr   = '0;
    s_axi_arvalid  = 1'b0;
    s_axi_rready   = 1'b0;
    m0_axi_awready = 1'b0;
    m0_axi_wready  = 1'b0;
    m0_axi_arready = 1'b0;
    m0_axi_rvalid  = 1'b0;
    m1_axi_awready = 1'b0;
    m1_axi_wready  = 1'b0;
    m1_axi_arready = 1'b0;
    m1_axi_rvalid  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!rst && (gnt != 2'b00)) begin
          if (g_wr) begin
            s_axi_awvalid = 1'b1;
            s_axi_wvalid  = 1'b1;
            s_axi_awaddr  = g_idx ? m1_axi_awaddr : m0_axi_awaddr;
            s_axi_wdata   = g_idx ? m1_axi_wdata : m0_axi_wdata;
            s_axi_wstrb   = g_idx ? m1_axi_wstrb : m0_axi_wstrb;
            wr_fire       = s_axi_awready & s_axi_wready;
            m0_axi_awready = wr_fire & ~g_idx;
            m0_axi_wready  = wr_fire & ~g_idx;
            m1_axi_awready = wr_fire & g_idx;
            m1_axi_wready  = wr_fire & g_idx;
          end else begin
            s_axi_arvalid  = 1'b1;
            s_axi_araddr   = g_idx ? m1_axi_araddr : m0_axi_araddr;
            rd_fire        = s_axi_arready;
            m0_axi_arready = rd_fire & ~g_idx;
            m1_axi_arready = rd_fire & g_idx;
            if (rd_fire) begin
              owner_d = g_idx;
              state_d = ST_RD_WAIT;
            end
          end
        end
      end
      ST_RD_WAIT: begin
        if (!rst) begin
          rready_sel    = owner_q ? m1_axi_rready : m0_axi_rready;
          s_axi_rready  = rready_sel;
          m0_axi_rvalid = s_axi_rvalid & ~owner_q;
          m1_axi_rvalid = s_axi_rvalid & owner_q;
          if (s_axi_rvalid && rready_sel) begin
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM state and read owner; reset drops any outstanding read.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      owner_q <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
    end
  end

`ifdef SRAM_ARB_FIXPRI_EN
  logic unused_fire;
  assign unused_fire = wr_fire;
  assign rr_ptr = 1'b0;
`else
  logic rr_q;
  assign rr_ptr = rr_q;
  // After any accepted transfer, favour the other master next time.
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_q <= 1'b0;
    end else if (wr_fire || rd_fire) begin
      rr_q <= ~g_idx;
    end
  end
`endif

endmodule

// File: tb/tb_sram_axi_arb2.sv
// Self-checking bench for sram_axi_arb2 with a behavioural SRAM slave.
module tb_sram_axi_arb2;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] m0_axi_awaddr, m0_axi_wdata, m0_axi_araddr, m0_axi_rdata;
  logic [3:0]  m0_axi_wstrb;
  logic        m0_axi_awvalid, m0_axi_awready, m0_axi_wvalid, m0_axi_wready;
  logic        m0_axi_arvalid, m0_axi_arready, m0_axi_rvalid, m0_axi_rready;
  logic [31:0] m1_axi_awaddr, m1_axi_wdata, m1_axi_araddr, m1_axi_rdata;
  logic [3:0]  m1_axi_wstrb;
  logic        m1_axi_awvalid, m1_axi_awready, m1_axi_wvalid, m1_axi_wready;
  logic        m1_axi_arvalid, m1_axi_arready, m1_axi_rvalid, m1_axi_rready;
  logic [31:0] s_axi_awaddr, s_axi_wdata, s_axi_araddr, s_axi_rdata;
  logic [3:0]  s_axi_wstrb;
  logic        s_axi_awvalid, s_axi_awready, s_axi_wvalid, s_axi_wready;
  logic        s_axi_arvalid, s_axi_arready, s_axi_rvalid, s_axi_rready;

  int vec_cnt = 0;
  int err_cnt = 0;

  logic [31:0] slv_mem [0:63];
  logic [31:0] ref_mem [0:63];
  logic [31:0] exp_q0[$];
  logic [31:0] exp_q1[$];
  int          gnt_q[$];

  always #5 clk = ~clk;

  sram_axi_arb2 dut (
    .clk            (clk),
    .rst            (rst),
    .m0_axi_awaddr  (m0_axi_awaddr),
    .m0_axi_awvalid (m0_axi_awvalid),
    .m0_axi_awready (m0_axi_awready),
    .m0_axi_wdata   (m0_axi_wdata),
    .m0_axi_wstrb   (m0_axi_wstrb),
    .m0_axi_wvalid  (m0_axi_wvalid),
    .m0_axi_wready  (m0_axi_wready),
    .m0_axi_araddr  (m0_axi_araddr),
    .m0_axi_arvalid (m0_axi_arvalid),
    .m0_axi_arready (m0_axi_arready),
    .m0_axi_rdata   (m0_axi_rdata),
    .m0_axi_rvalid  (m0_axi_rvalid),
    .m0_axi_rready  (m0_axi_rready),
    .m1_axi_awaddr  (m1_axi_awaddr),
    .m1_axi_awvalid (m1_axi_awvalid),
    .m1_axi_awready (m1_axi_awready),
    .m1_axi_wdata   (m1_axi_wdata),
    .m1_axi_wstrb   (m1_axi_wstrb),
    .m1_axi_wvalid  (m1_axi_wvalid),
    .m1_axi_wready  (m1_axi_wready),
    .m1_axi_araddr  (m1_axi_araddr),
    .m1_axi_arvalid (m1_axi_arvalid),
    .m1_axi_arready (m1_axi_arready),
    .m1_axi_rdata   (m1_axi_rdata),
    .m1_axi_rvalid  (m1_axi_rvalid),
    .m1_axi_rready  (m1_axi_rready),
    .s_axi_awaddr   (s_axi_awaddr),
    .s_axi_awvalid  (s_axi_awvalid),
    .s_axi_awready  (s_axi_awready),
    .s_axi_wdata    (s_axi_wdata),
    .s_axi_wstrb    (s_axi_wstrb),
    .s_axi_wvalid   (s_axi_wvalid),
    .s_axi_wready   (s_axi_wready),
    .s_axi_araddr   (s_axi_araddr),
    .s_axi_arvalid  (s_axi_arvalid),
    .s_axi_arready  (s_axi_arready),
    .s_axi_rdata    (s_axi_rdata),
    .s_axi_rvalid   (s_axi_rvalid),
    .s_axi_rready   (s_axi_rready)
  );

  // SRAM slave: AW+W accepted immediately, one-cycle read latency, one read outstanding.
  assign s_axi_awready = 1'b1;
  assign s_axi_wready  = 1'b1;
  assign s_axi_arready = !s_axi_rvalid;

  always @(posedge clk) begin
    if (rst) begin
      s_axi_rvalid <= 1'b0;
    end else begin
      if (s_axi_awvalid && s_axi_wvalid) begin
        for (int b = 0; b < 4; b++) begin
          if (s_axi_wstrb[b]) slv_mem[s_axi_awaddr[7:2]][b*8 +: 8] <= s_axi_wdata[b*8 +: 8];
        end
      end
      if (s_axi_arvalid && s_axi_arready) begin
        s_axi_rvalid <= 1'b1;
        s_axi_rdata  <= slv_mem[s_axi_araddr[7:2]];
      end else if (s_axi_rvalid && s_axi_rready) begin
        s_axi_rvalid <= 1'b0;
      end
    end
  end

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                        input logic [3:0] s);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (s[b]) r[b*8 +: 8] = d[b*8 +: 8];
    return r;
  endfunction

  task automatic idle_inputs();
    m0_axi_awaddr = '0; m0_axi_awvalid = 0; m0_axi_wdata = '0; m0_axi_wstrb = '0;
    m0_axi_wvalid = 0; m0_axi_araddr = '0; m0_axi_arvalid = 0; m0_axi_rready = 0;
    m1_axi_awaddr = '0; m1_axi_awvalid = 0; m1_axi_wdata = '0; m1_axi_wstrb = '0;
    m1_axi_wvalid = 0; m1_axi_araddr = '0; m1_axi_arvalid = 0; m1_axi_rready = 0;
  endtask

  task automatic apply_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    idle_inputs();
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
  endtask

  // Drive one write from master m; lat is the handshake cycle index, -1 on timeout.
  task automatic drive_write(input int m, input logic [31:0] a, input logic [31:0] d,
                             input logic [3:0] s, output int lat);
    ref_mem[a[7:2]] = merge(ref_mem[a[7:2]], d, s);
    if (m == 0) begin
      m0_axi_awaddr = a; m0_axi_wdata = d; m0_axi_wstrb = s;
      m0_axi_awvalid = 1; m0_axi_wvalid = 1;
    end else begin
      m1_axi_awaddr = a; m1_axi_wdata = d; m1_axi_wstrb = s;
      m1_axi_awvalid = 1; m1_axi_wvalid = 1;
    end
    lat = -1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if ((m == 0) ? (m0_axi_awready && m0_axi_wready) : (m1_axi_awready && m1_axi_wready)) begin
        lat = i;
        break;
      end
    end
    @(posedge clk); #1;
    if (m == 0) begin m0_axi_awvalid = 0; m0_axi_wvalid = 0; end
    else begin m1_axi_awvalid = 0; m1_axi_wvalid = 0; end
  endtask

  // Drive one read from master m with rready held high; returns data and arready latency.
  task automatic drive_read(input int m, input logic [31:0] a, output int lat,
                            output logic [31:0] data, output logic got);
    if (m == 0) begin m0_axi_araddr = a; m0_axi_arvalid = 1; m0_axi_rready = 1; end
    else begin m1_axi_araddr = a; m1_axi_arvalid = 1; m1_axi_rready = 1; end
    lat = -1; got = 0; data = '0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if ((m == 0) ? m0_axi_arready : m1_axi_arready) begin lat = i; break; end
    end
    @(posedge clk); #1;
    if (m == 0) m0_axi_arvalid = 0; else m1_axi_arvalid = 0;
    if (lat >= 0) begin
      for (int i = 0; i < 20; i++) begin
        @(negedge clk);
        if ((m == 0) ? m0_axi_rvalid : m1_axi_rvalid) begin
          data = (m == 0) ? m0_axi_rdata : m1_axi_rdata;
          got  = 1;
          break;
        end
      end
      @(posedge clk); #1;
    end
    if (m == 0) m0_axi_rready = 0; else m1_axi_rready = 0;
  endtask

  task automatic test_reset();
    logic [31:0] obs;
    rst = 1'b1;
    idle_inputs();
    m0_axi_arvalid = 1; m0_axi_awvalid = 1; m0_axi_wvalid = 1; m0_axi_rready = 1;
    m1_axi_arvalid = 1; m1_axi_awvalid = 1; m1_axi_wvalid = 1; m1_axi_rready = 1;
    @(posedge clk); @(negedge clk);
    obs = {18'd0, m0_axi_awready, m0_axi_wready, m0_axi_arready, m0_axi_rvalid,
           m1_axi_awready, m1_axi_wready, m1_axi_arready, m1_axi_rvalid,
           s_axi_awvalid, s_axi_wvalid, s_axi_arvalid, s_axi_rready,
           (|s_axi_awaddr), (|s_axi_araddr)};
    vec_cnt++;
    if (obs !== 32'd0) begin
      err_cnt++;
      $display("FAIL reset_ctrl: got %h expected %h", obs, 32'd0);
    end
    vec_cnt++;
    if ({m0_axi_rdata, m1_axi_rdata} !== 64'd0) begin
      err_cnt++;
      $display("FAIL reset_rdata: got %h expected %h", {m0_axi_rdata, m1_axi_rdata}, 64'd0);
    end
  endtask

  task automatic test_solo_write();
    int lat; logic [31:0] d, e; logic got;
    apply_reset();
    drive_write(0, 32'h10, 32'hDEADBEEF, 4'hF, lat);
    vec_cnt++;
    if (lat !== 0) begin
      err_cnt++;
      $display("FAIL solo_wr_latency: got %0d expected %0d", lat, 0);
    end
    exp_q0.push_back(ref_mem[4]);
    drive_read(0, 32'h10, lat, d, got);
    vec_cnt++;
    if (lat !== 0) begin
      err_cnt++;
      $display("FAIL solo_rd_latency: got %0d expected %0d", lat, 0);
    end
    e = exp_q0.pop_front();
    vec_cnt++;
    if (!got || d !== e) begin
      err_cnt++;
      $display("FAIL solo_rd_data: got %h (valid %0d) expected %h", d, got, e);
    end
  endtask

  task automatic test_contention();
    int obs_g[$]; int rv0, rv1, eg; logic a0, a1; logic [31:0] e;
    apply_reset();
    rv0 = 0; rv1 = 0;
    exp_q0.push_back(ref_mem[16]);
    exp_q1.push_back(ref_mem[17]);
    gnt_q.push_back(0);
    gnt_q.push_back(1);
    m0_axi_araddr = 32'h40; m0_axi_arvalid = 1; m0_axi_rready = 1;
    m1_axi_araddr = 32'h44; m1_axi_arvalid = 1; m1_axi_rready = 1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      a0 = m0_axi_arready; a1 = m1_axi_arready;
      if (a0) obs_g.push_back(0);
      if (a1) obs_g.push_back(1);
      if (m0_axi_rvalid) begin
        rv0++;
        e = (exp_q0.size() > 0) ? exp_q0.pop_front() : 32'hBAD0BAD0;
        vec_cnt++;
        if (m0_axi_rdata !== e) begin
          err_cnt++;
          $display("FAIL cont_m0_data: got %h expected %h", m0_axi_rdata, e);
        end
      end
      if (m1_axi_rvalid) begin
        rv1++;
        e = (exp_q1.size() > 0) ? exp_q1.pop_front() : 32'hBAD1BAD1;
        vec_cnt++;
        if (m1_axi_rdata !== e) begin
          err_cnt++;
          $display("FAIL cont_m1_data: got %h expected %h", m1_axi_rdata, e);
        end
      end
      @(posedge clk); #1;
      if (a0) m0_axi_arvalid = 0;
      if (a1) m1_axi_arvalid = 0;
    end
    m0_axi_rready = 0; m1_axi_rready = 0; m0_axi_arvalid = 0; m1_axi_arvalid = 0;
    vec_cnt++;
    if (obs_g.size() !== 2) begin
      err_cnt++;
      $display("FAIL cont_grant_count: got %0d expected %0d", obs_g.size(), 2);
    end
    for (int i = 0; i < 2; i++) begin
      eg = gnt_q.pop_front();
      vec_cnt++;
      if (i >= obs_g.size() || obs_g[i] !== eg) begin
        err_cnt++;
        $display("FAIL cont_grant_order[%0d]: got %0d expected %0d", i,
                 (i < obs_g.size()) ? obs_g[i] : -1, eg);
      end
    end
    vec_cnt++;
    if (rv0 !== 1 || rv1 !== 1) begin
      err_cnt++;
      $display("FAIL cont_rvalid_count: got %0d/%0d expected 1/1", rv0, rv1);
    end
  endtask

  task automatic test_round_robin();
    int g, eg, lat; logic [31:0] d, e; logic got;
    apply_reset();
    m0_axi_awaddr = 32'h80; m0_axi_wdata = 32'h11111111; m0_axi_wstrb = 4'hF;
    m1_axi_awaddr = 32'h84; m1_axi_wdata = 32'h22222222; m1_axi_wstrb = 4'hF;
    m0_axi_awvalid = 1; m0_axi_wvalid = 1; m1_axi_awvalid = 1; m1_axi_wvalid = 1;
    ref_mem[32] = 32'h11111111;
`ifndef SRAM_ARB_FIXPRI_EN
    ref_mem[33] = 32'h22222222;
`endif
    for (int i = 0; i < 8; i++) begin
`ifdef SRAM_ARB_FIXPRI_EN
      gnt_q.push_back(0);
`else
      gnt_q.push_back(i % 2);
`endif
    end
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      g = -1;
      if (m0_axi_awready && m0_axi_wready) g = 0;
      if (m1_axi_awready && m1_axi_wready) g = (g == 0) ? 2 : 1;
      eg = gnt_q.pop_front();
      vec_cnt++;
      if (g !== eg) begin
        err_cnt++;
        $display("FAIL rr_grant[%0d]: got %0d expected %0d", i, g, eg);
      end
      @(posedge clk); #1;
    end
    idle_inputs();
    exp_q0.push_back(ref_mem[33]);
    drive_read(0, 32'h84, lat, d, got);
    e = exp_q0.pop_front();
    vec_cnt++;
    if (!got || d !== e) begin
      err_cnt++;
      $display("FAIL rr_readback: got %h (valid %0d) expected %h", d, got, e);
    end
  endtask

  task automatic test_backpressure();
    int lat; logic [31:0] d, e; logic got;
    apply_reset();
    exp_q1.push_back(ref_mem[17]);
    m1_axi_araddr = 32'h44; m1_axi_arvalid = 1; m1_axi_rready = 0;
    @(negedge clk);
    vec_cnt++;
    if (m1_axi_arready !== 1'b1) begin
      err_cnt++;
      $display("FAIL bp_m1_arready: got %b expected %b", m1_axi_arready, 1'b1);
    end
    @(posedge clk); #1;
    m1_axi_arvalid = 0;
    m0_axi_awaddr = 32'h30; m0_axi_wdata = 32'hCAFEF00D; m0_axi_wstrb = 4'hF;
    m0_axi_awvalid = 1; m0_axi_wvalid = 1;
    ref_mem[12] = 32'hCAFEF00D;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      vec_cnt++;
      if ({m0_axi_awready, m0_axi_wready, m0_axi_rvalid, m1_axi_rvalid} !== 4'b0001) begin
        err_cnt++;
        $display("FAIL bp_stall[%0d]: got %b expected %b", k,
                 {m0_axi_awready, m0_axi_wready, m0_axi_rvalid, m1_axi_rvalid}, 4'b0001);
      end
      @(posedge clk); #1;
    end
    m1_axi_rready = 1;
    @(negedge clk);
    e = exp_q1.pop_front();
    vec_cnt++;
    if (m1_axi_rvalid !== 1'b1 || m1_axi_rdata !== e || m0_axi_awready !== 1'b0) begin
      err_cnt++;
      $display("FAIL bp_r_handshake: got rvalid %b data %h awready0 %b expected 1 %h 0",
               m1_axi_rvalid, m1_axi_rdata, m0_axi_awready, e);
    end
    @(posedge clk); #1;
    m1_axi_rready = 0;
    @(negedge clk);
    vec_cnt++;
    if ({m0_axi_awready, m0_axi_wready} !== 2'b11) begin
      err_cnt++;
      $display("FAIL bp_m0_grant_after: got %b expected %b",
               {m0_axi_awready, m0_axi_wready}, 2'b11);
    end
    @(posedge clk); #1;
    idle_inputs();
    exp_q0.push_back(ref_mem[12]);
    drive_read(0, 32'h30, lat, d, got);
    e = exp_q0.pop_front();
    vec_cnt++;
    if (!got || d !== e) begin
      err_cnt++;
      $display("FAIL bp_readback: got %h (valid %0d) expected %h", d, got, e);
    end
  endtask

  task automatic test_mixed();
    logic [31:0] e; logic got; logic [31:0] d;
    apply_reset();
    ref_mem[8] = merge(ref_mem[8], 32'h5A5AA5A5, 4'b0110);
    exp_q0.push_back(ref_mem[8]);
    m0_axi_awaddr = 32'h20; m0_axi_wdata = 32'h5A5AA5A5; m0_axi_wstrb = 4'b0110;
    m0_axi_awvalid = 1; m0_axi_wvalid = 1;
    m0_axi_araddr = 32'h20; m0_axi_arvalid = 1; m0_axi_rready = 1;
    @(negedge clk);
    vec_cnt++;
    if ({m0_axi_awready, m0_axi_wready, m0_axi_arready} !== 3'b110) begin
      err_cnt++;
      $display("FAIL mixed_write_first: got %b expected %b",
               {m0_axi_awready, m0_axi_wready, m0_axi_arready}, 3'b110);
    end
    @(posedge clk); #1;
    m0_axi_awvalid = 0; m0_axi_wvalid = 0;
    @(negedge clk);
    vec_cnt++;
    if (m0_axi_arready !== 1'b1) begin
      err_cnt++;
      $display("FAIL mixed_read_next: got %b expected %b", m0_axi_arready, 1'b1);
    end
    @(posedge clk); #1;
    m0_axi_arvalid = 0;
    got = 0; d = '0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (m0_axi_rvalid) begin d = m0_axi_rdata; got = 1; break; end
    end
    e = exp_q0.pop_front();
    vec_cnt++;
    if (!got || d !== e) begin
      err_cnt++;
      $display("FAIL mixed_read_data: got %h (valid %0d) expected %h", d, got, e);
    end
    @(posedge clk); #1;
    m0_axi_rready = 0;
  endtask

  task automatic test_reset_rd_wait();
    logic [31:0] e;
    apply_reset();
    m0_axi_araddr = 32'h40; m0_axi_arvalid = 1; m0_axi_rready = 0;
    @(negedge clk);
    @(posedge clk); #1;
    m0_axi_arvalid = 0;
    @(negedge clk);
    vec_cnt++;
    if (m0_axi_rvalid !== 1'b1) begin
      err_cnt++;
      $display("FAIL rstrw_pending: got %b expected %b", m0_axi_rvalid, 1'b1);
    end
    @(posedge clk); #1;
    rst = 1;
    m1_axi_araddr = 32'h48; m1_axi_arvalid = 1; m1_axi_rready = 1;
    exp_q1.push_back(ref_mem[18]);
    @(negedge clk);
    vec_cnt++;
    if ({m0_axi_awready, m0_axi_wready, m0_axi_arready, m0_axi_rvalid, m1_axi_awready,
         m1_axi_wready, m1_axi_arready, m1_axi_rvalid, s_axi_rready} !== 9'd0) begin
      err_cnt++;
      $display("FAIL rstrw_outputs: got %b expected %b",
               {m0_axi_awready, m0_axi_wready, m0_axi_arready, m0_axi_rvalid, m1_axi_awready,
                m1_axi_wready, m1_axi_arready, m1_axi_rvalid, s_axi_rready}, 9'd0);
    end
    @(posedge clk); #1;
    rst = 0;
    @(negedge clk);
    vec_cnt++;
    if ({m1_axi_arready, m0_axi_rvalid} !== 2'b10) begin
      err_cnt++;
      $display("FAIL rstrw_idle: got %b expected %b", {m1_axi_arready, m0_axi_rvalid}, 2'b10);
    end
    @(posedge clk); #1;
    m1_axi_arvalid = 0;
    @(negedge clk);
    e = exp_q1.pop_front();
    vec_cnt++;
    if (m1_axi_rvalid !== 1'b1 || m1_axi_rdata !== e) begin
      err_cnt++;
      $display("FAIL rstrw_m1_read: got %b %h expected 1 %h", m1_axi_rvalid, m1_axi_rdata, e);
    end
    @(posedge clk); #1;
    m1_axi_rready = 0;
  endtask

  initial begin
    for (int i = 0; i < 64; i++) begin
      slv_mem[i] = 32'hA5000000 | (i * 32'h00010203);
      ref_mem[i] = 32'hA5000000 | (i * 32'h00010203);
    end
    test_reset();
    test_solo_write();
    test_contention();
    test_round_robin();
    test_backpressure();
    test_mixed();
    test_reset_rd_wait();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
